// File: rtl/ring_phase_decoder.sv
// Monitor/decoder for a one-hot ring counter: turns the sampled ring state into a
// phase index, counts rotations and flags illegal codes or out-of-order steps.
module ring_phase_decoder #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    localparam int PHASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               sample_en,
    input  logic [WIDTH-1:0]   q_in,
    input  logic               err_ack,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               wrap,
    output logic [CNT_W-1:0]   rot_count,
    output logic               onehot_err,
    output logic               step_err,
    output logic               fault
);

    typedef enum logic [1:0] {S_SEARCH, S_LOCKED, S_FAULT} state_t;

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(WIDTH - 1);

    state_t               r_state, w_state_n;
    logic [WIDTH-1:0]     r_prev, w_prev_n;
    logic [PHASE_W-1:0]   r_phase, w_phase_n;
    logic                 r_pv, w_pv_n;
    logic                 r_wrap, w_wrap_n;
    logic [CNT_W-1:0]     r_rot, w_rot_n;
    logic                 r_oe, w_oe_n;
    logic                 r_se, w_se_n;
    logic                 r_fault, w_fault_n;

    logic                 w_legal;
    logic                 w_hold;
    logic                 w_advance;
    logic [WIDTH-1:0]     w_expected;
    logic [PHASE_W-1:0]   w_idx;

    assign w_legal    = $onehot(q_in);
    assign w_expected = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
    assign w_hold     = (q_in == r_prev);
    assign w_advance  = (q_in == w_expected);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (q_in[i]) w_idx = PHASE_W'(i);
    end

    // State register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) r_state <= S_SEARCH;
        else       r_state <= w_state_n;
    end

    // Next-state logic
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_SEARCH: if (sample_en && w_legal) w_state_n = S_LOCKED;
            S_LOCKED: if (sample_en && !w_hold && !w_advance) w_state_n = S_FAULT;
            S_FAULT:  if (err_ack) w_state_n = S_SEARCH;
            default:  w_state_n = S_SEARCH;
        endcase
    end

    // Output/datapath next values; pulses default low every cycle
    always_comb begin
        w_prev_n  = r_prev;
        w_phase_n = r_phase;
        w_pv_n    = r_pv;
        w_wrap_n  = 1'b0;
        w_rot_n   = r_rot;
        w_oe_n    = 1'b0;
        w_se_n    = 1'b0;
        w_fault_n = r_fault;
        case (r_state)
            S_SEARCH: begin
                if (sample_en) begin
                    if (w_legal) begin
                        w_phase_n = w_idx;
                        w_pv_n    = 1'b1;
                        w_prev_n  = q_in;
                    end else begin
                        w_oe_n = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (sample_en && !w_hold) begin
                    if (w_advance) begin
                        w_prev_n  = q_in;
                        w_phase_n = (r_phase == LAST_PHASE) ? '0 : r_phase + PHASE_W'(1);
                        if (r_phase == LAST_PHASE) begin
                            w_wrap_n = 1'b1;
                            w_rot_n  = r_rot + CNT_W'(1);
                        end
                    end else begin
                        w_oe_n    = !w_legal;
                        w_se_n    = w_legal;
                        w_fault_n = 1'b1;
                        w_pv_n    = 1'b0;
                    end
                end
            end
            S_FAULT: begin
                if (err_ack) begin
                    w_fault_n = 1'b0;
                    w_prev_n  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_prev  <= '0;
            r_phase <= '0;
            r_pv    <= 1'b0;
            r_wrap  <= 1'b0;
            r_rot   <= '0;
            r_oe    <= 1'b0;
            r_se    <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_prev  <= w_prev_n;
            r_phase <= w_phase_n;
            r_pv    <= w_pv_n;
            r_wrap  <= w_wrap_n;
            r_rot   <= w_rot_n;
            r_oe    <= w_oe_n;
            r_se    <= w_se_n;
            r_fault <= w_fault_n;
        end
    end

    assign phase       = r_phase;
    assign phase_valid = r_pv;
    assign wrap        = r_wrap;
    assign rot_count   = r_rot;
    assign onehot_err  = r_oe;
    assign step_err    = r_se;
    assign fault       = r_fault;

endmodule

// File: tb/tb_ring_phase_decoder.sv
// Bench for ring_phase_decoder: directed scenarios with literal expectations, then
// random ring traffic, all checked every cycle against a behavioural model.
module tb_ring_phase_decoder;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       sample_en = 1'b0;
    logic [3:0] q_in = 4'b0;
    logic       err_ack = 1'b0;

    logic [1:0] phase, phase2;
    logic       pv, pv2, wrap, wrap2, oe, oe2, se, se2, flt, flt2;
    logic [7:0] rot;
    logic [1:0] rot2;

    ring_phase_decoder #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .clear(clear), .sample_en(sample_en), .q_in(q_in), .err_ack(err_ack),
        .phase(phase), .phase_valid(pv), .wrap(wrap), .rot_count(rot),
        .onehot_err(oe), .step_err(se), .fault(flt));

    ring_phase_decoder #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .clear(clear), .sample_en(sample_en), .q_in(q_in), .err_ack(err_ack),
        .phase(phase2), .phase_valid(pv2), .wrap(wrap2), .rot_count(rot2),
        .onehot_err(oe2), .step_err(se2), .fault(flt2));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=searching, 1=locked, 2=faulted
    int m_mode, m_prev, m_phase, m_rot;
    bit m_pv, m_wrap, m_oe, m_se, m_fault;

    function automatic int rotl(input int v);
        return ((v << 1) | (v >> (W - 1))) & ((1 << W) - 1);
    endfunction

    task automatic mdl_reset();
        m_mode = 0; m_prev = 0; m_phase = 0; m_rot = 0;
        m_pv = 0; m_wrap = 0; m_oe = 0; m_se = 0; m_fault = 0;
    endtask

    task automatic mdl_step(input bit s, input int q, input bit a);
        bit legal;
        legal = ($countones(q) == 1);
        m_wrap = 0; m_oe = 0; m_se = 0;
        if (m_mode == 2) begin
            if (a) begin m_mode = 0; m_fault = 0; m_prev = 0; end
        end else if (s) begin
            if (m_mode == 0) begin
                if (legal) begin
                    m_mode = 1; m_phase = $clog2(q); m_pv = 1; m_prev = q;
                end else m_oe = 1;
            end else if (q == m_prev) begin
            end else if (q == rotl(m_prev)) begin
                m_prev = q;
                m_phase = (m_phase + 1) % W;
                if (m_phase == 0) begin m_wrap = 1; m_rot++; end
            end else begin
                m_mode = 2; m_fault = 1; m_pv = 0;
                if (legal) m_se = 1; else m_oe = 1;
            end
        end
    endtask

    task automatic step(input bit s, input logic [3:0] q, input bit a);
        sample_en = s; q_in = q; err_ack = a;
        @(posedge clk);
        mdl_step(s, int'(q), a);
        #1;
    endtask

    task automatic sync_clear();
        clear = 1'b1;
        mdl_reset();
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("phase",  32'(phase), 32'(m_phase));
            chk("pvalid", 32'(pv),    32'(m_pv));
            chk("wrap",   32'(wrap),  32'(m_wrap));
            chk("rot",    32'(rot),   32'(m_rot % 256));
            chk("oherr",  32'(oe),    32'(m_oe));
            chk("steperr",32'(se),    32'(m_se));
            chk("fault",  32'(flt),   32'(m_fault));
            chk("rot2",   32'(rot2),  32'(m_rot % 4));
            chk("wrap2",  32'(wrap2), 32'(m_wrap));
        end
    end

    initial begin
        logic [3:0] g;
        mdl_reset();
        #1;
        chk("rst_phase", 32'(phase), 0);
        chk("rst_pv", 32'(pv), 0);
        chk("rst_rot", 32'(rot), 0);
        chk("rst_fault", 32'(flt), 0);
        @(posedge clk); #1;
        clear = 1'b0;
        chk_en = 1;

        // Lock and wrap
        step(1, 4'b0001, 0); chk("lk_ph0", 32'(phase), 0); chk("lk_pv", 32'(pv), 1);
        step(1, 4'b0010, 0); chk("lk_ph1", 32'(phase), 1);
        step(1, 4'b0100, 0); chk("lk_ph2", 32'(phase), 2);
        step(1, 4'b1000, 0); chk("lk_ph3", 32'(phase), 3); chk("lk_nowrap", 32'(wrap), 0);
        step(1, 4'b0001, 0); chk("lk_wrap", 32'(wrap), 1); chk("lk_rot", 32'(rot), 1);
        chk("lk_ph0b", 32'(phase), 0);
        step(0, 4'b0010, 0); chk("wrap_gap", 32'(wrap), 0);

        // Hold
        step(1, 4'b0010, 0);
        repeat (3) step(1, 4'b0010, 0);
        chk("hold_ph", 32'(phase), 1); chk("hold_flt", 32'(flt), 0);
        step(1, 4'b0100, 0); chk("hold_adv", 32'(phase), 2);

        // Skip and recovery
        step(1, 4'b1000, 0);
        step(1, 4'b0001, 0);
        step(1, 4'b0100, 0);
        chk("skip_se", 32'(se), 1); chk("skip_flt", 32'(flt), 1);
        chk("skip_pv", 32'(pv), 0); chk("skip_ph", 32'(phase), 0);
        step(1, 4'b1000, 0); chk("skip_quiet", 32'(se), 0);
        step(1, 4'b0110, 0); chk("skip_quiet_oe", 32'(oe), 0);
        step(1, 4'b0001, 1); chk("ack_flt", 32'(flt), 0); chk("ack_pv", 32'(pv), 0);
        step(1, 4'b0001, 0); chk("relock_pv", 32'(pv), 1); chk("relock_ph", 32'(phase), 0);

        // Illegal codes
        step(1, 4'b0110, 0); chk("ilB_oe", 32'(oe), 1); chk("ilB_flt", 32'(flt), 1);
        step(0, 4'b0000, 1);
        step(1, 4'b0000, 0); chk("ilA_oe", 32'(oe), 1); chk("ilA_flt", 32'(flt), 0);
        chk("ilA_pv", 32'(pv), 0);

        // Counter wrap on the narrow instance
        sync_clear();
        step(1, 4'b0001, 0);
        g = 4'b0001;
        for (int r = 1; r <= 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                g = {g[2:0], g[3]};
                step(1, g, 0);
            end
            chk("cw_wrap2", 32'(wrap2), 1);
            chk("cw_rot2", 32'(rot2), 32'(r % 4));
        end
        chk("cw_rot8", 32'(rot), 4);

        // Async clear while locked at phase 2, rot_count 3
        sync_clear();
        step(1, 4'b0001, 0);
        g = 4'b0001;
        for (int k = 0; k < 14; k++) begin
            g = {g[2:0], g[3]};
            step(1, g, 0);
        end
        chk("ar_pre_ph", 32'(phase), 2); chk("ar_pre_rot", 32'(rot), 3);
        #2;
        clear = 1'b1; sample_en = 1'b1; q_in = 4'b1000; err_ack = 1'b1;
        mdl_reset();
        #1;
        chk("ar_ph", 32'(phase), 0); chk("ar_pv", 32'(pv), 0);
        chk("ar_rot", 32'(rot), 0); chk("ar_flt", 32'(flt), 0);
        @(posedge clk); #1;
        clear = 1'b0;
        step(1, 4'b1000, 0); chk("ar_relock_ph", 32'(phase), 3); chk("ar_relock_pv", 32'(pv), 1);

        // Random ring traffic with stalls, skips, garbage and acks
        g = 4'b0001;
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [3:0] q;
            bit s;
            r = $urandom_range(0, 99);
            s = 1'b1;
            if (r < 55) begin g = {g[2:0], g[3]}; q = g; end
            else if (r < 70) q = g;
            else if (r < 78) q = 4'($urandom_range(0, 15));
            else if (r < 84) begin g = 4'(1 << $urandom_range(0, 3)); q = g; end
            else begin s = 1'b0; q = 4'($urandom_range(0, 15)); end
            step(s, q, ($urandom_range(0, 9) == 0));
        end

        @(negedge clk); #1;
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ring_phase_decoder.md
Name: ring_phase_decoder

Overview:
- Receive side of the 4-bit one-hot ring counter: samples the ring state bus, decodes it to a binary phase index and checks every step for legality.
- Counts full rotations and flags illegal codes or skipped and backward steps.
- Sits beside any ring_counter instance as its monitor/decoder. Downstream logic uses its phase and fault outputs instead of the raw one-hot bus.

Parameters:
- WIDTH, 4, number of ring stages (>=2); bit 0 is the preset stage, and the ring shifts bit i -> bit i+1, bit WIDTH-1 -> bit 0.
- CNT_W, 8, width of rotation counter.
- PHASE_W, clog2(WIDTH), derived localparam, width of the phase output.

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  asynchronous active-high reset.
- sample_en  in  1  q_in is valid this cycle; one sample per ring-counter clock.
- q_in  in  WIDTH  ring counter state (q_out of the ring counter).
- err_ack  in  1  acknowledges a fault and restarts acquisition.
- phase  out  PHASE_W  index of the hot bit.
- phase_valid  out  1  decoder locked; phase meaningful.
- wrap  out  1  one-cycle pulse when phase advances WIDTH-1 -> 0.
- rot_count  out  CNT_W  completed rotations, modulo 2^CNT_W.
- onehot_err  out  1  one-cycle pulse: sampled code not one-hot.
- step_err  out  1  one-cycle pulse: legal one-hot but not hold or +1 step.
- fault  out  1  sticky fault flag.

Behaviour:
- Reset (clear=1, async, immediate):
  - state SEARCH.
  - phase=0, phase_valid=0, wrap=0, rot_count=0, onehot_err=0, step_err=0, fault=0.
  - Registered previous sample = 0.
- All outputs are registered. A sample taken at edge N is reflected after edge N, so latency is 1 cycle.
- Pulses (wrap, onehot_err, step_err) last exactly one cycle. They are 0 on any cycle without sample_en.
- Legal code: exactly one bit set. Expected next code: rotate-left-by-1 of the previous sample.
- FSM states: SEARCH, LOCKED, FAULT.
- SEARCH:
  - sample_en with legal code -> LOCKED; phase=index of hot bit; phase_valid=1; previous sample=q_in; no wrap, rot_count unchanged.
  - sample_en with illegal code (incl. 0000, the normal post-clear value) -> onehot_err pulse, stay SEARCH, fault stays 0.
- LOCKED, on sample_en:
  - q_in == previous sample: hold. No change, no error (stalled ring).
  - q_in == expected next code: phase = (phase+1) mod WIDTH. If the old phase was WIDTH-1, pulse wrap and increment rot_count, which wraps 2^CNT_W-1 -> 0. Previous sample updated.
  - q_in not one-hot: onehot_err pulse -> FAULT.
  - Any other one-hot value (skip, backward step): step_err pulse -> FAULT.
  - Entering FAULT: fault=1, phase_valid=0, phase and rot_count frozen at last good values.
- FAULT:
  - Samples ignored; no further error pulses.
  - err_ack=1 -> SEARCH, fault=0, previous sample=0. rot_count is retained, not cleared.
  - err_ack and sample_en in the same cycle: ack wins, sample discarded.
- err_ack in SEARCH or LOCKED: no effect.
- clear mid-operation overrides everything, including a coincident sample_en/err_ack. Acquisition restarts in SEARCH after release.
- No combinational path from inputs to outputs.

Test Plan:
- Lock and wrap (WIDTH=4):
  - Stimulus: clear pulse, then sample_en=1 with q_in 0001,0010,0100,1000,0001.
  - Response: phase 0,1,2,3,0; phase_valid=1 from first sample; wrap pulses only after the 5th sample; rot_count=1; no errors.
- Hold:
  - Stimulus: locked at 0010, q_in 0010 for 3 samples, then 0100.
  - Response: phase stays 1, then 2; no error pulses; fault=0.
- Skip and recovery:
  - Stimulus: locked at 0001, q_in=0100; then further samples; then err_ack=1 with sample_en=1 and q_in=0001.
  - Response: step_err pulse 1 cycle; fault=1; phase_valid=0; phase frozen at 0. Further samples give no pulses. The ack cycle enters SEARCH with the sample ignored. The next 0001 sample relocks at phase 0.
- Illegal codes:
  - Stimulus A: in SEARCH, q_in=0000.
  - Response A: onehot_err pulse; fault stays 0; state stays SEARCH.
  - Stimulus B: in LOCKED, q_in=0110.
  - Response B: onehot_err pulse; fault=1.
- Counter wrap:
  - Stimulus: CNT_W=2, 4 full rotations.
  - Response: rot_count 1,2,3,0; wrap pulse on each rotation.
- Async reset:
  - Stimulus: assert clear between clock edges while locked at phase 2, rot_count=3.
  - Response: all outputs 0 immediately, before the next edge. After release, first 1000 sample locks at phase 3.
